btb_update_ctrl: RTL
====================

Name: btb_update_ctrl

Overview:
- Write-side producer for the direct-mapped BTB. It takes resolved control-flow results from the two execute-stage branch units and detects mispredictions.
- It emits one registered front-end redirect per cycle for the oldest mispredict.
- BTB write requests go into an 8-entry FIFO and drain one per cycle onto the BTB update port (update_btb, ex_pc, actual_target_address, ex_is_ret, ex_is_branch).
- Sits between execute/branch units and the BTB and fetch PC mux.

Parameters:
- XLEN, 32, address/data width
- QDEPTH, 8, update FIFO entries (power of 2, >=4)

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; empties FIFO, drops same-cycle results
- res_valid0  in  1  result valid, slot 0 (older)
- res0  in  br_res_t  resolved result, slot 0
- res_valid1  in  1  result valid, slot 1 (younger)
- res1  in  br_res_t  resolved result, slot 1
- res_ready  out  1  both slots may be presented this cycle
- update_btb  out  1  BTB write strobe
- ex_pc  out  XLEN  BTB write PC
- ex_is_ret  out  1  entry is return
- ex_is_branch  out  1  entry is conditional branch
- actual_target_address  out  XLEN  BTB write target
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  XLEN  correct next PC
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- br_res_t fields: pc, target (XLEN), taken, is_ret, is_branch, pred_taken, pred_target (XLEN).
- Address arithmetic:
  - seq = pc + 4, mod 2^XLEN.
  - actual_next = taken ? target : seq.
  - pred_next = pred_taken ? pred_target : seq.
- mispredict_i = res_valid_i & (actual_next != pred_next).
- need_write_i = res_valid_i & taken & (!pred_taken | pred_target != target).
- A slot is accepted only when res_valid_i & res_ready & !flush.
- Slot 1 is squashed (no write, no redirect) when slot 0 is accepted and mispredicts, because slot 1 is wrong-path.
- Enqueue order is slot 0 then slot 1; zero, one or two pushes per cycle.
- res_ready = (q_count <= QDEPTH-2). It is derived from registered count and asserted even when queue space is needed for only one slot. Upstream must hold results while res_ready=0.
- Pop:
  - update_btb = !empty, driven from head registers.
  - The head pops every cycle it is non-empty; the BTB always accepts.
- Latency:
  - A result accepted at edge N appears on update_btb in the cycle after edge N if the queue was empty.
  - Otherwise it appears after all older entries drain, in FIFO order.
- Simultaneous pop and push of 2 is legal. New count = count + pushes - pop.
- Full: pushes never exceed capacity, guaranteed by res_ready. No overflow path is required; an assertion covers it.
- Empty: update_btb=0. Output payload holds its last value (don't-care).
- Redirect:
  - redirect_valid is registered: high for one cycle after the edge that accepted a mispredicting slot.
  - redirect_pc = that slot's actual_next. Slot 0 has priority.
- flush:
  - Read/write pointers and count cleared on the next edge.
  - Same-cycle results dropped.
  - redirect_valid=0 next cycle.
  - Dropping updates is safe because the BTB is a hint.
- reset: pointers, count, update_btb, redirect_valid and res_ready-relevant state cleared. After reset: q_count=0, res_ready=1, redirect_pc=0. Reset mid-drain discards all entries.
- Two accepted writes to the same BTB index in one cycle are both enqueued; the later write wins in the BTB.

Decomposition:
- Shared package branch_pkg: br_res_t, btb_upd_t {pc, target, is_ret, is_branch}, INSTR_BYTES=4.
- One sub-module: upd_fifo, a 2-write/1-read synchronous FIFO of btb_upd_t with count, flush and reset.
- Mispredict and filter logic stay in the top level.

Test Plan:
- Reset then idle -> q_count=0, res_ready=1, update_btb=0, redirect_valid=0.
- Slot 0 pc=0x100, taken, target=0x200, pred_taken=0 -> next cycle: redirect_valid=1 with redirect_pc=0x200; update_btb=1 with ex_pc=0x100, actual_target_address=0x200.
- Slot 0 pc=0x100 correctly predicted (taken, pred_target=0x200) plus slot 1 pc=0x104 not taken, pred_taken=0 -> no redirect, no write, q_count stays 0.
- Slot 0 pc=0x300 taken mispredict to 0x400, slot 1 pc=0x304 taken with a new target -> one enqueue only; redirect_pc=0x400; slot 1 never written.
- Present 2 writes per cycle continuously with pc=0x1000+8k -> q_count climbs to 7, res_ready deasserts at count>=7. Writes drain in order 0x1000, 0x1004, ... one per cycle, with no loss and no overflow.
- Queue at count 5, assert flush with both slots valid -> next cycle q_count=0, update_btb=0, redirect_valid=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch-resolution and BTB-update types, plus the next-PC arithmetic
// used when comparing resolved and predicted control flow.
package branch_pkg;

  localparam int unsigned BR_XLEN     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [BR_XLEN-1:0] pc;
    logic [BR_XLEN-1:0] target;
    logic               taken;
    logic               is_ret;
    logic               is_branch;
    logic               pred_taken;
    logic [BR_XLEN-1:0] pred_target;
  } br_res_t;

  typedef struct packed {
    logic [BR_XLEN-1:0] pc;
    logic [BR_XLEN-1:0] target;
    logic               is_ret;
    logic               is_branch;
  } btb_upd_t;

  function automatic logic [BR_XLEN-1:0] seq_pc(input logic [BR_XLEN-1:0] pc);
    return pc + BR_XLEN'(INSTR_BYTES);
  endfunction

  function automatic logic [BR_XLEN-1:0] actual_next(input br_res_t r);
    return r.taken ? r.target : seq_pc(r.pc);
  endfunction

  function automatic logic [BR_XLEN-1:0] pred_next(input br_res_t r);
    return r.pred_taken ? r.pred_target : seq_pc(r.pc);
  endfunction

  // A taken branch needs a BTB entry unless the BTB already predicted it exactly.
  function automatic logic needs_write(input br_res_t r);
    return r.taken & (~r.pred_taken | (r.pred_target != r.target));
  endfunction

  function automatic btb_upd_t to_upd(input br_res_t r);
    btb_upd_t u;
    u.pc        = r.pc;
    u.target    = r.target;
    u.is_ret    = r.is_ret;
    u.is_branch = r.is_branch;
    return u;
  endfunction

endpackage

// File: rtl/upd_fifo.sv
// Two-write/one-read synchronous FIFO of BTB updates; the head pops every
// cycle it is non-empty.
module upd_fifo
  import branch_pkg::*;
#(
  parameter int unsigned QDEPTH = 8,
  localparam int unsigned AW = $clog2(QDEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push0,
  input  btb_upd_t      data0,
  input  logic          push1,
  input  btb_upd_t      data1,
  output btb_upd_t      head,
  output logic          empty,
  output logic [CW-1:0] count
);

  btb_upd_t        mem [QDEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            pop;
  logic [CW-1:0]   next_count;

  assign empty = (count == '0);
  assign pop   = ~empty;
  assign head  = mem[rptr];

  always_comb begin
    next_count = count + CW'(push0) + CW'(push1) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push0) + AW'(push1);
      rptr  <= rptr + AW'(pop);
      count <= next_count;
    end
  end

  // A lone slot-1 push takes the current write slot so entries stay contiguous.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (push0) mem[wptr] <= data0;
      if (push1) mem[push0 ? wptr + AW'(1) : wptr] <= data1;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
    next_count <= CW'(QDEPTH));

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-side producer: detects mispredicts from two branch units, issues a
// registered fetch redirect and queues BTB updates for one-per-cycle drain.
module btb_update_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned XLEN   = BR_XLEN,
  parameter int unsigned QDEPTH = 8
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      res_valid0,
  input  br_res_t                   res0,
  input  logic                      res_valid1,
  input  br_res_t                   res1,
  output logic                      res_ready,
  output logic                      update_btb,
  output logic [XLEN-1:0]           ex_pc,
  output logic                      ex_is_ret,
  output logic                      ex_is_branch,
  output logic [XLEN-1:0]           actual_target_address,
  output logic                      redirect_valid,
  output logic [XLEN-1:0]           redirect_pc,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] act0, act1;
  logic            acc0, acc1;
  logic            mis0, mis1;
  logic            push0, push1;
  btb_upd_t        head;
  logic            empty;

  // Readiness comes from the registered count and reserves room for two pushes.
  assign res_ready = (q_count <= CW'(QDEPTH - 2));

  always_comb begin
    act0  = actual_next(res0);
    act1  = actual_next(res1);
    acc0  = res_valid0 & res_ready & ~flush;
    mis0  = acc0 & (act0 != pred_next(res0));
    // Slot 1 is on the wrong path once the older slot mispredicts.
    acc1  = res_valid1 & res_ready & ~flush & ~mis0;
    mis1  = acc1 & (act1 != pred_next(res1));
    push0 = acc0 & needs_write(res0);
    push1 = acc1 & needs_write(res1);
  end

  upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .flush (flush),
    .push0 (push0),
    .data0 (to_upd(res0)),
    .push1 (push1),
    .data1 (to_upd(res1)),
    .head  (head),
    .empty (empty),
    .count (q_count)
  );

  assign update_btb            = ~empty;
  assign ex_pc                 = head.pc;
  assign actual_target_address = head.target;
  assign ex_is_ret             = head.is_ret;
  assign ex_is_branch          = head.is_branch;

  always_ff @(posedge CLK) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mis0 | mis1;
      if (mis0)      redirect_pc <= act0;
      else if (mis1) redirect_pc <= act1;
    end
  end

endmodule
